// File: rtl/fflags_seq.sv
// fflags_seq: merges pipeline FP flags and late divide/sqrt completion flags
// into one sticky fflags update stream, counts outstanding long ops, gates the
// long-op issue/completion handshakes and holds FP CSR accesses until every
// outstanding flag update has been committed.
module fflags_seq #(
  parameter type  cvw_t  = logic,
  parameter cvw_t P      = '0,
  parameter int   MAXOUT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FpuLongIssueM,
  output logic       FpuLongReadyM,
  input  logic       FpuLongDoneValid,
  input  logic [4:0] FpuLongDoneFlags,
  output logic       FpuLongDoneReady,
  input  logic       PipeFlagsValidM,
  input  logic [4:0] PipeFlagsM,
  input  logic       CSRFpAccessM,
  output logic [4:0] SetFflagsM,
  output logic       SetFflagsValidM,
  output logic       FcsrStallM
);

  // The counter is 3 bits wide, so at most 7 ops can be tracked.
  localparam bit         CFG_OK  = (MAXOUT >= 1) && (MAXOUT <= 7) && ($bits(P) > 0);
  localparam logic [2:0] MAX_CNT = 3'(MAXOUT);

  if (!CFG_OK) begin : g_bad_cfg
    $error("fflags_seq: MAXOUT must be in 1..7");
  end

  // IDLE: nothing outstanding, nothing buffered.
  // BUSY: at least one long op outstanding (buffer may also hold flags).
  // DRAIN: last op accepted, its flags are being merged this cycle.
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [2:0] out_cnt_q, out_cnt_d;
  logic [4:0] pend_flags_q;
  logic       pend_valid_q, pend_valid_d;
  logic       issue_acc, done_acc;

  // Handshakes from registered state only; counter and FSM next-state.
  always_comb begin
    FpuLongReadyM    = out_cnt_q < MAX_CNT;
    FpuLongDoneReady = out_cnt_q != 3'd0;
    issue_acc        = FpuLongIssueM & FpuLongReadyM;
    done_acc         = FpuLongDoneValid & FpuLongDoneReady;
    out_cnt_d        = out_cnt_q + {2'b0, issue_acc} - {2'b0, done_acc};
    pend_valid_d     = done_acc;
    state_d          = state_q;
    case (state_q)
      IDLE:    if (issue_acc) state_d = BUSY;
      BUSY:    if (out_cnt_d == 3'd0) state_d = DRAIN;
      DRAIN:   state_d = issue_acc ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; the flag buffer refills on accept and empties otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_cnt_q    <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_flags_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      out_cnt_q    <= out_cnt_d;
      pend_valid_q <= pend_valid_d;
      if (done_acc) pend_flags_q <= FpuLongDoneFlags;
    end
  end

  // Sticky-OR merge of both flag sources; stall FP CSR access until idle.
  always_comb begin
    SetFflagsM      = (PipeFlagsValidM ? PipeFlagsM : 5'd0) |
                      (pend_valid_q ? pend_flags_q : 5'd0);
    SetFflagsValidM = PipeFlagsValidM | pend_valid_q;
    FcsrStallM      = CSRFpAccessM & (state_q != IDLE);
  end

  // Issuing while not ready is a pipeline protocol error.
  a_issue_ready: assert property (@(posedge clk) disable iff (reset)
    FpuLongIssueM |-> FpuLongReadyM);

endmodule

// File: tb/tb_fflags_seq.sv
// Directed bench for fflags_seq: a counter/buffer model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_fflags_seq;
  localparam int MAXOUT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       FpuLongIssueM, FpuLongReadyM;
  logic       FpuLongDoneValid, FpuLongDoneReady;
  logic [4:0] FpuLongDoneFlags;
  logic       PipeFlagsValidM;
  logic [4:0] PipeFlagsM;
  logic       CSRFpAccessM;
  logic [4:0] SetFflagsM;
  logic       SetFflagsValidM, FcsrStallM;

  int n_chk  = 0;
  int n_fail = 0;

  fflags_seq #(.MAXOUT(MAXOUT)) dut (
    .clk(clk), .reset(reset),
    .FpuLongIssueM(FpuLongIssueM), .FpuLongReadyM(FpuLongReadyM),
    .FpuLongDoneValid(FpuLongDoneValid), .FpuLongDoneFlags(FpuLongDoneFlags),
    .FpuLongDoneReady(FpuLongDoneReady),
    .PipeFlagsValidM(PipeFlagsValidM), .PipeFlagsM(PipeFlagsM),
    .CSRFpAccessM(CSRFpAccessM),
    .SetFflagsM(SetFflagsM), .SetFflagsValidM(SetFflagsValidM),
    .FcsrStallM(FcsrStallM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: number of ops in flight and the flags of the op accepted last cycle.
  int       m_out;
  bit       m_pv, m_ok = 1'b0, m_acc, m_iss;
  bit [4:0] m_pf;

  always @(posedge clk) begin
    if (reset) begin
      m_out = 0; m_pv = 1'b0; m_pf = 5'd0; m_ok = 1'b1;
    end else begin
      m_acc = FpuLongDoneValid && (m_out > 0);
      m_iss = FpuLongIssueM && (m_out < MAXOUT);
      m_out = m_out + int'(m_iss) - int'(m_acc);
      m_pv  = m_acc;
      if (m_acc) m_pf = FpuLongDoneFlags;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_ready",     32'(FpuLongReadyM),    32'(m_out < MAXOUT));
      chk("m_doneready", 32'(FpuLongDoneReady), 32'(m_out > 0));
      chk("m_setvalid",  32'(SetFflagsValidM),  32'(PipeFlagsValidM || m_pv));
      chk("m_setflags",  32'(SetFflagsM),
          32'((PipeFlagsValidM ? PipeFlagsM : 5'd0) | (m_pv ? m_pf : 5'd0)));
      chk("m_stall",     32'(FcsrStallM),       32'(CSRFpAccessM && (m_out > 0 || m_pv)));
    end
  end

  task automatic drive(input bit iss, input bit dv, input bit [4:0] df,
                       input bit pv, input bit [4:0] pf, input bit csr);
    FpuLongIssueM    = iss;
    FpuLongDoneValid = dv;
    FpuLongDoneFlags = df;
    PipeFlagsValidM  = pv;
    PipeFlagsM       = pf;
    CSRFpAccessM     = csr;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    FpuLongIssueM = 0; FpuLongDoneValid = 0; FpuLongDoneFlags = 0;
    PipeFlagsValidM = 0; PipeFlagsM = 0; CSRFpAccessM = 0;
    adv(); adv();
    reset = 1'b0;

    // Reset state, then a stray completion is refused.
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    chk("rst_ready", 32'(FpuLongReadyM), 32'd1);
    chk("rst_doneready", 32'(FpuLongDoneReady), 32'd0);
    chk("rst_setv", 32'(SetFflagsValidM), 32'd0);
    chk("rst_set", 32'(SetFflagsM), 32'd0);
    chk("rst_stall", 32'(FcsrStallM), 32'd0);
    adv();
    drive(0, 1, 5'b10000, 0, 5'd0, 0);
    chk("stray_doneready", 32'(FpuLongDoneReady), 32'd0);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    chk("stray_setv", 32'(SetFflagsValidM), 32'd0);
    adv();

    // One fdiv: issue c0, completion c5, CSR access held from c1.
    drive(1, 0, 5'd0, 0, 5'd0, 0); adv();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 5'd0, 0, 5'd0, 1);
      chk("div_stall_wait", 32'(FcsrStallM), 32'd1);
      adv();
    end
    drive(0, 1, 5'b00001, 0, 5'd0, 1);
    chk("div_stall_c5", 32'(FcsrStallM), 32'd1);
    chk("div_doneready_c5", 32'(FpuLongDoneReady), 32'd1);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    chk("div_stall_c6", 32'(FcsrStallM), 32'd1);
    chk("div_set_c6", 32'(SetFflagsM), 32'h01);
    chk("div_setv_c6", 32'(SetFflagsValidM), 32'd1);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    chk("div_stall_c7", 32'(FcsrStallM), 32'd0);
    chk("div_setv_c7", 32'(SetFflagsValidM), 32'd0);
    adv();

    // MAXOUT limit, full-counter completion, simultaneous issue+accept.
    drive(1, 0, 5'd0, 0, 5'd0, 0); chk("max_ready_c0", 32'(FpuLongReadyM), 32'd1); adv();
    drive(1, 0, 5'd0, 0, 5'd0, 0); chk("max_ready_c1", 32'(FpuLongReadyM), 32'd1); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0); chk("max_ready_c2", 32'(FpuLongReadyM), 32'd0); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0); chk("max_ready_c3", 32'(FpuLongReadyM), 32'd0); adv();
    drive(0, 1, 5'b00100, 0, 5'd0, 0); chk("max_ready_c4", 32'(FpuLongReadyM), 32'd0); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    chk("max_ready_c5", 32'(FpuLongReadyM), 32'd1);
    chk("max_set_c5", 32'(SetFflagsM), 32'h04);
    adv();
    drive(1, 1, 5'b00010, 0, 5'd0, 0); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    chk("max_ready_c7", 32'(FpuLongReadyM), 32'd1);
    chk("max_doneready_c7", 32'(FpuLongDoneReady), 32'd1);
    chk("max_set_c7", 32'(SetFflagsM), 32'h02);
    adv();
    drive(0, 1, 5'b10001, 0, 5'd0, 0); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    chk("max_doneready_c9", 32'(FpuLongDoneReady), 32'd0);
    chk("max_set_c9", 32'(SetFflagsM), 32'h11);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0); chk("max_setv_c10", 32'(SetFflagsValidM), 32'd0); adv();

    // Merge of late and pipeline flags; issue during the drain cycle.
    drive(1, 0, 5'd0, 0, 5'd0, 0); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0); adv();
    drive(0, 1, 5'b01000, 0, 5'd0, 0); adv();
    drive(1, 0, 5'd0, 1, 5'b00011, 0);
    chk("mrg_set", 32'(SetFflagsM), 32'h0b);
    chk("mrg_setv", 32'(SetFflagsValidM), 32'd1);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    chk("mrg_stall_busy", 32'(FcsrStallM), 32'd1);
    chk("mrg_doneready", 32'(FpuLongDoneReady), 32'd1);
    adv();
    drive(0, 1, 5'd0, 0, 5'd0, 1); adv();
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    chk("mrg_stall_drain", 32'(FcsrStallM), 32'd1);
    chk("mrg_setv_zero", 32'(SetFflagsValidM), 32'd1);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 1); chk("mrg_stall_done", 32'(FcsrStallM), 32'd0); adv();

    // Reset for one cycle with two ops in flight.
    drive(1, 0, 5'd0, 0, 5'd0, 0); adv();
    drive(1, 0, 5'd0, 0, 5'd0, 0); adv();
    reset = 1'b1;
    drive(0, 0, 5'd0, 0, 5'd0, 1);
    chk("rmid_stall_pre", 32'(FcsrStallM), 32'd1);
    adv();
    reset = 1'b0;
    drive(0, 1, 5'b11111, 0, 5'd0, 1);
    chk("rmid_stall", 32'(FcsrStallM), 32'd0);
    chk("rmid_doneready", 32'(FpuLongDoneReady), 32'd0);
    chk("rmid_ready", 32'(FpuLongReadyM), 32'd1);
    adv();
    drive(0, 0, 5'd0, 0, 5'd0, 0);
    chk("rmid_setv", 32'(SetFflagsValidM), 32'd0);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
